// File: rtl/sample_buffer.sv
// Circular sample store addressed by absolute 32-bit indices, with a drop window and freeze.
// Optional macro SAMPLE_BUF_OVERWRITE_EN: writes while full discard the oldest sample.
module sample_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          freeze,
  input  logic          drop_valid,
  input  logic [31:0]   drop_to,
  input  logic [31:0]   index,
  output logic [31:0]   value,
  output logic          index_valid,
  output logic [31:0]   first_idx,
  output logic [31:0]   next_idx,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [31:0]        mem [DEPTH];
  logic               wr;
  logic signed [31:0] drop_dist;
  logic [31:0]        span;
  logic [31:0]        first_drop;
  logic [31:0]        first_n;
  logic [31:0]        next_n;
  logic [AW:0]        count_n;
  logic [31:0]        rel;
`ifdef SAMPLE_BUF_OVERWRITE_EN
  logic [31:0]        span_drop;
`endif

`ifdef SAMPLE_BUF_OVERWRITE_EN
  assign in_ready = !freeze;
`else
  assign in_ready = !freeze && !full;
`endif

  assign wr = in_valid && in_ready;

  // Drop target is clamped into [first_idx, next_idx]; differences keep 2^32 wrap transparent.
  always_comb begin
    drop_dist  = $signed(drop_to - first_idx);
    span       = next_idx - first_idx;
    first_drop = first_idx;
    if (drop_valid && !freeze && (drop_dist >= 0)) begin
      first_drop = ($unsigned(drop_dist) > span) ? next_idx : drop_to;
    end
    first_n = first_drop;
    next_n  = next_idx;
`ifdef SAMPLE_BUF_OVERWRITE_EN
    span_drop = next_idx - first_drop;
`endif
    if (wr) begin
      next_n = next_idx + 32'd1;
`ifdef SAMPLE_BUF_OVERWRITE_EN
      if (span_drop == 32'(DEPTH)) first_n = first_drop + 32'd1;
`endif
    end
    count_n = (AW+1)'(next_n - first_n);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      first_idx <= '0;
      next_idx  <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      first_idx <= first_n;
      next_idx  <= next_n;
      count     <= count_n;
      full      <= (count_n == (AW+1)'(DEPTH));
      empty     <= (count_n == '0);
    end
  end

  // Storage is deliberately not reset; count=0 makes stale contents unreachable.
  always_ff @(posedge Clk) begin
    if (wr) mem[next_idx[AW-1:0]] <= in_data;
  end

  assign rel         = index - first_idx;
  assign index_valid = (rel < 32'(count));
  assign value       = index_valid ? mem[index[AW-1:0]] : '0;

endmodule
